// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter: FSM state encoding, requester indices,
// default widths and the opcode list used by the alu behind the arbiter.
package alu_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_RESP  = 2'd2;

  localparam int REQ_EXEC   = 0;
  localparam int REQ_BRANCH = 1;

  localparam int DATA_LENGTH_DEF        = 16;
  localparam int INSTRUCTION_LENGTH_DEF = 8;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_INC  = 8'h03;
  localparam logic [7:0] OP_CMP  = 8'h04;
  localparam logic [7:0] OP_TEST = 8'h05;
  localparam logic [7:0] OP_SETC = 8'h06;
  localparam logic [7:0] OP_CLC  = 8'h07;
  localparam logic [7:0] OP_JL   = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;

  // Requester index of a one-hot winner vector.
  function automatic logic winner_idx(input logic [1:0] onehot);
    return onehot[REQ_BRANCH];
  endfunction

endpackage

// File: rtl/alu_arb_rr_pick.sv
// Two-input round-robin picker: on a tie the requester that did not win last time wins.
module alu_arb_rr_pick (
  input  logic [1:0] req_valid,
  input  logic       rr_last,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req_valid)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = rr_last ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between the execute unit (0) and the branch unit (1),
// and owns the architectural flag register. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int dataLength        = DATA_LENGTH_DEF,
  parameter int instructionLength = INSTRUCTION_LENGTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_valid,
  input  logic [instructionLength-1:0] req0_ir,
  input  logic [instructionLength-1:0] req1_ir,
  input  logic [dataLength-1:0]        req0_a,
  input  logic [dataLength-1:0]        req1_a,
  input  logic [dataLength-1:0]        req0_b,
  input  logic [dataLength-1:0]        req1_b,
  output logic [1:0]                   req_grant,
  output logic [1:0]                   resp_valid,
  input  logic [1:0]                   resp_ready,
  output logic [dataLength-1:0]        resp_data,
  output logic                         resp_wr,
  output logic                         flag_C,
  output logic                         flag_Z,
  output logic                         flag_S,
  output logic                         flag_V,
  output logic                         flag_P,
  output logic                         alu_enable,
  output logic [dataLength-1:0]        alu_in1,
  output logic [dataLength-1:0]        alu_in2,
  output logic [instructionLength-1:0] alu_ir,
  input  logic [dataLength-1:0]        alu_out,
  input  logic                         alu_ready,
  input  logic                         alu_C,
  input  logic                         alu_Z,
  input  logic                         alu_S,
  input  logic                         alu_V,
  input  logic                         alu_P,
  output logic [1:0]                   state_dbg
);

  // Handshake: req_grant[i] pulses for the single IDLE cycle in which requester i's
  // operands are captured; resp_valid[i] then holds in RESP until resp_ready[i] is
  // seen high on a rising edge, after which it drops and the arbiter returns to IDLE.

  logic [1:0]                   state;
  logic [1:0]                   winner;
  logic [1:0]                   pick;
  logic [4:0]                   flags;
  logic [dataLength-1:0]        op_a;
  logic [dataLength-1:0]        op_b;
  logic [instructionLength-1:0] op_ir;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick = req_valid[REQ_EXEC] ? 2'b01 : {req_valid[REQ_BRANCH], 1'b0};
`else
  logic rr_last;

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   rr_last <= 1'b1;
    else if (state == ARB_ISSUE) rr_last <= winner_idx(winner);
  end

  alu_arb_rr_pick u_rr_pick (
    .req_valid (req_valid),
    .rr_last   (rr_last),
    .winner    (pick)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      winner    <= 2'b00;
      op_a      <= '0;
      op_b      <= '0;
      op_ir     <= '0;
      resp_data <= '0;
      resp_wr   <= 1'b0;
      flags     <= 5'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick != 2'b00) begin
            winner <= pick;
            op_ir  <= pick[REQ_BRANCH] ? req1_ir : req0_ir;
            op_a   <= pick[REQ_BRANCH] ? req1_a  : req0_a;
            op_b   <= pick[REQ_BRANCH] ? req1_b  : req0_b;
            state  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          resp_data <= alu_out;
          resp_wr   <= alu_ready;
          flags     <= {alu_C, alu_Z, alu_S, alu_V, alu_P};
          state     <= ARB_RESP;
        end
        ARB_RESP: begin
          if ((resp_ready & winner) != 2'b00) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Grant is decoded combinationally so that acceptance shows in the IDLE cycle itself.
  assign req_grant  = (state == ARB_IDLE && !reset) ? pick : 2'b00;
  assign resp_valid = (state == ARB_RESP) ? winner : 2'b00;
  assign alu_enable = (state == ARB_ISSUE);
  assign alu_in1    = op_a;
  assign alu_in2    = op_b;
  assign alu_ir     = op_ir;
  assign {flag_C, flag_Z, flag_S, flag_V, flag_P} = flags;
  assign state_dbg  = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural alu model and an expected-response queue.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int W  = 2 + DW + 1 + 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [IW-1:0] req0_ir, req1_ir;
  logic [DW-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [1:0]    req_grant, resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_wr;
  logic          flag_C, flag_Z, flag_S, flag_V, flag_P;
  logic          alu_enable;
  logic [DW-1:0] alu_in1, alu_in2, alu_out;
  logic [IW-1:0] alu_ir;
  logic          alu_ready, alu_C, alu_Z, alu_S, alu_V, alu_P;
  logic [1:0]    state_dbg;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.dataLength(DW), .instructionLength(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req0_ir(req0_ir), .req1_ir(req1_ir), .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b), .req_grant(req_grant),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_wr(resp_wr), .flag_C(flag_C), .flag_Z(flag_Z), .flag_S(flag_S),
    .flag_V(flag_V), .flag_P(flag_P), .alu_enable(alu_enable),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ir(alu_ir), .alu_out(alu_out),
    .alu_ready(alu_ready), .alu_C(alu_C), .alu_Z(alu_Z), .alu_S(alu_S),
    .alu_V(alu_V), .alu_P(alu_P), .state_dbg(state_dbg)
  );

  // Behavioural alu: V on subtraction reports the borrow; flag-only and jump ops
  // pass the untouched flags through from the registered flag outputs.
  logic [DW:0]   sum;
  logic [DW-1:0] res;
  logic          upd, wr;
  always_comb begin
    sum = '0; res = '0; upd = 1'b0; wr = 1'b0; alu_out = '0;
    {alu_C, alu_Z, alu_S, alu_V, alu_P} = {flag_C, flag_Z, flag_S, flag_V, flag_P};
    case (alu_ir)
      OP_ADD: begin
        sum = {1'b0, alu_in1} + {1'b0, alu_in2}; res = sum[DW-1:0]; upd = 1'b1;
        alu_C = sum[DW]; alu_V = (alu_in1[DW-1] == alu_in2[DW-1]) && (res[DW-1] != alu_in1[DW-1]);
        alu_out = res; wr = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        sum = {1'b0, alu_in1} + {1'b0, ~alu_in2} + 1'b1; res = sum[DW-1:0]; upd = 1'b1;
        alu_C = sum[DW]; alu_V = ~sum[DW];
        if (alu_ir == OP_SUB) begin alu_out = res; wr = 1'b1; end
      end
      OP_INC: begin
        sum = {1'b0, alu_in1} + 1'b1; res = sum[DW-1:0]; upd = 1'b1;
        alu_C = sum[DW]; alu_V = res[DW-1] & ~alu_in1[DW-1];
        alu_out = res; wr = 1'b1;
      end
      OP_TEST: begin res = alu_in1 & alu_in2; upd = 1'b1; alu_C = 1'b0; alu_V = 1'b0; end
      OP_SETC: alu_C = 1'b1;
      OP_CLC:  alu_C = 1'b0;
      OP_JL:   begin alu_out = (flag_S ^ flag_V) ? '1 : '0; wr = 1'b1; end
      OP_JMP:  begin alu_out = '1; wr = 1'b1; end
      default: ;
    endcase
    if (upd) begin alu_Z = (res == '0); alu_S = res[DW-1]; alu_P = ~^res; end
    alu_ready = wr & alu_enable;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {flag_C, flag_Z, flag_S, flag_V, flag_P};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    step(); step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_req(input int idx, input logic [IW-1:0] ir,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (idx == 0) begin req0_ir = ir; req0_a = a; req0_b = b; end
    else          begin req1_ir = ir; req1_a = a; req1_b = b; end
    req_valid[idx] = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] who, input logic [DW-1:0] d,
                          input logic w, input logic [4:0] f);
    exp_q.push_back({who, d, w, f});
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_grant != 2'b00) break;
    end
    check(tag, req_grant, exp);
  endtask

  // Called at a drive point; returns at the drive point of the following IDLE cycle.
  task automatic collect(input string tag, input int hold);
    logic [W-1:0]  e;
    logic [1:0]    who;
    logic [DW-1:0] d0;
    logic [4:0]    f0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) break;
    end
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'bx}};
    who = e[W-1 -: 2];
    check($sformatf("%s_valid", tag), resp_valid, who);
    check($sformatf("%s_data", tag), resp_data, e[W-3 -: DW]);
    check($sformatf("%s_wr", tag), resp_wr, e[5]);
    check($sformatf("%s_flags", tag), flags_now(), e[4:0]);
    check($sformatf("%s_en_off", tag), alu_enable, 1'b0);
    d0 = e[W-3 -: DW]; f0 = e[4:0];
    for (int i = 0; i < hold; i++) begin
      step(); resp_ready = ~who;
      @(negedge clk);
      check($sformatf("%s_hold_valid", tag), resp_valid, who);
      check($sformatf("%s_hold_data", tag), resp_data, d0);
      check($sformatf("%s_hold_flags", tag), flags_now(), f0);
      check($sformatf("%s_hold_grant", tag), req_grant, 2'b00);
    end
    step(); resp_ready = who;
    @(negedge clk);
    check($sformatf("%s_rel_grant", tag), req_grant, 2'b00);
    check($sformatf("%s_rel_valid", tag), resp_valid, who);
    step(); resp_ready = 2'b00;
    #1;
    check($sformatf("%s_drop", tag), resp_valid, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_w;
    req0_ir = '0; req1_ir = '0; req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
    do_reset();

    // Reset values.
    @(negedge clk);
    check("rst_state", state_dbg, ARB_IDLE);
    check("rst_grant", req_grant, 2'b00);
    check("rst_valid", resp_valid, 2'b00);
    check("rst_data", resp_data, 16'h0000);
    check("rst_wr", resp_wr, 1'b0);
    check("rst_flags", flags_now(), 5'b00000);
    check("rst_en", alu_enable, 1'b0);
    check("rst_in1", alu_in1, 16'h0000);
    check("rst_ir", alu_ir, 8'h00);
    step();

    // Simultaneous requests from reset: requester 0 first, then 1, then 0 again.
    drive_req(0, OP_SUB, 16'd5, 16'd5);
    drive_req(1, OP_INC, 16'hFFFF, 16'h0000);
    push_exp(2'b01, 16'h0000, 1'b1, 5'b11001);
    push_exp(2'b10, 16'h0000, 1'b1, 5'b11001);
    wait_grant("tie_first", 2'b01);
    step(); req_valid[0] = 1'b0;
    collect("sub", 0);
    wait_grant("tie_second", 2'b10);
    step(); req_valid[1] = 1'b0;
    collect("inc", 0);
    drive_req(0, OP_ADD, 16'd1, 16'd2);
    drive_req(1, OP_TEST, 16'hF0F0, 16'h0FF0);
    push_exp(2'b01, 16'h0003, 1'b1, 5'b00001);
    push_exp(2'b10, 16'h0000, 1'b0, 5'b00001);
    wait_grant("tie_third", 2'b01);
    step(); req_valid[0] = 1'b0;
    collect("add12", 0);
    wait_grant("test_grant", 2'b10);
    step(); req_valid[1] = 1'b0;
    collect("test", 0);

    // Compare then conditional jump on requester 1.
    drive_req(1, OP_CMP, 16'd3, 16'd7);
    push_exp(2'b10, 16'h0000, 1'b0, 5'b00111);
    wait_grant("cmp_grant", 2'b10);
    step(); req_valid[1] = 1'b0;
    collect("cmp", 0);
    drive_req(1, OP_JL, 16'h0000, 16'h0000);
    push_exp(2'b10, 16'h0000, 1'b1, 5'b00111);
    wait_grant("jl_grant", 2'b10);
    step(); req_valid[1] = 1'b0;
    collect("jl", 0);

    // Response held for 10 cycles while requester 1 waits.
    drive_req(0, OP_SETC, 16'h0000, 16'h0000);
    push_exp(2'b01, 16'h0000, 1'b0, 5'b10111);
    wait_grant("setc_grant", 2'b01);
    step(); req_valid[0] = 1'b0;
    drive_req(1, OP_CLC, 16'h0000, 16'h0000);
    push_exp(2'b10, 16'h0000, 1'b0, 5'b00111);
    collect("setc", 10);
    wait_grant("clc_grant", 2'b10);
    step(); req_valid[1] = 1'b0;
    collect("clc", 0);

    // Reset asserted during RESP drops the in-flight response.
    drive_req(0, OP_SUB, 16'd5, 16'd5);
    push_exp(2'b01, 16'h0000, 1'b1, 5'b11001);
    wait_grant("mid_grant", 2'b01);
    step(); req_valid[0] = 1'b0;
    step();
    @(negedge clk);
    check("mid_pre_valid", resp_valid, 2'b01);
    check("mid_pre_flags", flags_now(), 5'b11001);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", resp_valid, 2'b00);
    check("mid_rst_flags", flags_now(), 5'b00000);
    check("mid_rst_state", state_dbg, ARB_IDLE);
    check("mid_rst_data", resp_data, 16'h0000);
    void'(exp_q.pop_front());
    step();
    reset = 1'b0;

    // ADD overflow with cycle-exact latency.
    drive_req(0, OP_ADD, 16'h7FFF, 16'h0001);
    push_exp(2'b01, 16'h8000, 1'b1, 5'b00110);
    wait_grant("add_grant", 2'b01);
    check("add_grant_en", alu_enable, 1'b0);
    step(); req_valid[0] = 1'b0;
    @(negedge clk);
    check("add_issue_en", alu_enable, 1'b1);
    check("add_issue_in1", alu_in1, 16'h7FFF);
    check("add_issue_in2", alu_in2, 16'h0001);
    check("add_issue_ir", alu_ir, OP_ADD);
    check("add_issue_flags", flags_now(), 5'b00000);
    check("add_issue_valid", resp_valid, 2'b00);
    step();
    @(negedge clk);
    check("add_lat_valid", resp_valid, 2'b01);
    check("add_resp_in1", alu_in1, 16'h7FFF);
    step();
    collect("add", 0);

    // Both requesters continuously valid for four operations.
    do_reset();
    drive_req(0, OP_JMP, 16'h0000, 16'h0000);
    drive_req(1, OP_JMP, 16'h0000, 16'h0000);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_w = 2'b01;
`else
      exp_w = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      push_exp(exp_w, 16'hFFFF, 1'b1, 5'b00000);
      wait_grant($sformatf("loop%0d_grant", k), exp_w);
      step();
      collect($sformatf("loop%0d", k), 0);
    end
    req_valid = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-port arbiter/sequencer sharing the single combinational alu between requester 0 (execute unit) and requester 1 (branch/condition unit).
- Accepts one operation per grant, drives the alu for exactly one cycle, registers the result and flags, and returns a response to the winning requester.
- Holds the architectural flag register (C, Z, S, V, P) seen by the rest of the CPU.

Parameters:
- dataLength, `dataLength (alu_parameters.h): operand/result width.
- instructionLength, `instructionLength: IR width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  bit i = requester i has an operation pending
- req0_ir / req1_ir  in  instructionLength  opcode per requester
- req0_a / req1_a  in  dataLength  operand in1
- req0_b / req1_b  in  dataLength  operand in2
- req_grant  out  2  one-hot, 1-cycle pulse: operation of requester i accepted this cycle
- resp_valid  out  2  one-hot: response for requester i held
- resp_ready  in  2  requester i consumes response
- resp_data  out  dataLength  registered alu result
- resp_wr  out  1  registered alu output_ready (1 = result is writeback-worthy)
- flag_C, flag_Z, flag_S, flag_V, flag_P  out  1 each  registered flag register
- alu_enable  out  1  to alu enable_alu
- alu_in1, alu_in2  out  dataLength  to alu
- alu_ir  out  instructionLength  to alu
- alu_out  in  dataLength;  alu_ready  in  1;  alu_C/Z/S/V/P  in  1 each  from alu

Behaviour:
- Reset: state=IDLE, req_grant=0, resp_valid=0, resp_data=0, resp_wr=0, all flags 0, alu_enable=0, alu_in1/in2/ir=0, rr_last=1 (requester 0 wins first tie).
- FSM IDLE -> ISSUE -> RESP -> IDLE.
- IDLE: if req_valid!=0, pick winner (round-robin: on tie, requester != rr_last wins; else the single requester). Pulse req_grant[winner]; latch winner's ir/a/b into operand registers; go ISSUE. No request: stay IDLE.
- ISSUE (exactly 1 cycle): alu_enable=1, alu_in1/in2/ir driven from operand registers. On the clock edge ending ISSUE: resp_data<=alu_out, resp_wr<=alu_ready, flags<=alu_C..P, rr_last<=winner; go RESP.
- Flag-only ops (TEST, CMP, SETC, CLC) complete identically; resp_wr=0 because the alu does not assert output_ready for them. Jump ops return all-ones/all-zeros in resp_data with resp_wr=1.
- RESP: resp_valid[winner]=1, resp_data/resp_wr held stable. When resp_ready[winner]=1: resp_valid drops next cycle, state IDLE. resp_ready of the non-winner is ignored.
- Latency: grant at cycle N, alu_enable at N+1, resp_valid from N+2. Minimum 3 cycles per operation (no back-to-back issue).
- alu_enable is 0 in IDLE and RESP. The alu inputs hold their last values in those states.
- Flags change only on the ISSUE->RESP edge. They are stable at all other times, including while the other requester waits.
- req_valid deasserted after grant: no effect, because the operation is already latched.
- Reset mid-operation (any state): immediate return to reset values. The in-flight operation is dropped with no response.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; rr_last is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Shared package/header: state encoding (ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_RESP=2'd2) and requester index constants.
- Continue to use commands_list.h opcodes and alu_parameters.h widths.
- One natural sub-module: alu_arb_rr_pick (2-input round-robin picker: req_valid, rr_last -> one-hot winner). It is bypassed under ALU_ARB_FIXED_PRIO_EN.

Test Plan (dataLength=16, alu instantiated behind arbiter):
- Reset held mid-RESP -> resp_valid=0, flags=0, state IDLE within the same cycle. After release, a new req0 is granted normally.
- req0 ADD a=16'h7FFF b=16'h0001 alone -> grant[0] at N, alu_enable at N+1, resp_valid[0] at N+2, resp_data=16'h8000, resp_wr=1, V=1, S=1, Z=0, C=0.
- Both valid from reset: req0 SUB 5-5, req1 INC 16'hFFFF -> req0 granted first (resp_data=0, Z=1, C=1), then req1 (resp_data=0, Z=1). Round-robin order confirmed by a third simultaneous request going to req0.
- req1 CMP a=3 b=7 -> resp_wr=0, C=0, S=1, Z=0. Then req1 JL -> resp_data=16'h0000 (S==V=1 after borrow check per alu flags). resp_data must match the alu's all-ones/all-zeros output for the registered flags.
- resp_ready held low 10 cycles in RESP -> resp_valid[winner], resp_data and flags stable. Pending req from the other port is not granted until after the release cycle.
- ALU_ARB_FIXED_PRIO_EN defined, both requesters continuously valid for 4 ops -> all 4 grants to requester 0.
